pipe_ctrl: RTL

Central pipeline sequencing unit for the five-stage MangoMIPS32 integer pipeline. It merges per-stage stall requests and the MEM-stage exception/redirect request into per-register stall and flush vectors for the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It defers a redirect while an instruction-bus fetch is outstanding, and it keeps stall/exception performance counters. It sits beside the datapath; every pipeline register takes its stall/flush bit from here.

---
 rtl/pipe_ctrl_pkg.sv | 49 ++++
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl_counter.sv | 21 ++
 rtl/pipe_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and helpers for the pipeline sequencing unit.
package pipe_ctrl_pkg;

  // Width of the per-register stall/flush vectors.
  localparam int VEC_W = 5;

  // Bit positions within the stall/flush vectors.
  localparam int STG_PC  = 0;  // PC register
  localparam int STG_ID  = 1;  // IF/ID register
  localparam int STG_EX  = 2;  // ID/EX register
  localparam int STG_MEM = 3;  // EX/MEM register
  localparam int STG_WB  = 4;  // MEM/WB register

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Redirect FSM encodings.
  localparam logic [0:0] PC_IDLE = 1'b0;
  localparam logic [0:0] PC_WAIT = 1'b1;

  typedef logic [VEC_W-1:0] vec_t;

  typedef struct packed {
    vec_t stall;
    vec_t flush;
  } ctrl_vec_t;

  // Vectors for plain stall handling; req = {mem, ex, id, if}.
  // The highest requesting stage holds itself and everything upstream
  // and injects a bubble into the register just downstream of it.
  function automatic ctrl_vec_t stall_level(input logic [3:0] req);
    ctrl_vec_t v;
    v = '0;
    if (req[3]) begin
      v.stall = 5'b01111;
      v.flush = 5'b10000;
    end else if (req[2]) begin
      v.stall = 5'b00111;
      v.flush = 5'b01000;
    end else if (req[1]) begin
      v.stall = 5'b00011;
      v.flush = 5'b00100;
    end else if (req[0]) begin
      v.stall = 5'b00001;
      v.flush = 5'b00010;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the datapath and the pipeline controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic             if_stallreq;
  logic             id_stallreq;
  logic             ex_stallreq;
  logic             mem_stallreq;
  logic             exc_req;
  logic [31:0]      exc_pc;
  logic             ibus_busy;
  vec_t             stall;
  vec_t             flush;
  logic             flush_pc_valid;
  logic [31:0]      flush_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] exc_cnt;

  // Datapath side: raises requests, consumes stall/flush/redirect.
  modport master (
    output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    output exc_req, exc_pc, ibus_busy,
    input  stall, flush, flush_pc_valid, flush_pc, stall_cnt, exc_cnt
  );

  // Controller side.
  modport slave (
    input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    input  exc_req, exc_pc, ibus_busy,
    output stall, flush, flush_pc_valid, flush_pc, stall_cnt, exc_cnt
  );
endinterface

// File: rtl/pipe_ctrl_counter.sv
// Wrapping event counter used for the performance statistics.
module pipe_ctrl_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles; wraps naturally modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing unit: merges stall requests and the MEM-stage
// exception into per-register stall/flush vectors, defers redirects
// behind an outstanding instruction fetch, and counts stalls/exceptions.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [31:0] pend_pc;
  logic        accept;
  ctrl_vec_t   ctl;
  logic        pc_valid;
  logic [31:0] pc_target;

  // Output vectors and next state from inputs and current state.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt = state;
    ctl       = '0;
    pc_valid  = 1'b0;
    pc_target = pend_pc;
    accept    = 1'b0;
    if (rst) begin
      // Bubble everything while reset is held.
      ctl.flush = '1;
      pc_target = ZERO_WORD;
    end else if (state == PC_WAIT) begin
      // Fetch in flight: hold PC, squash the whole pipe, and discard
      // whatever the outstanding fetch returns through the IF/ID flush.
      ctl.flush = 5'b11110;
      if (bus.ibus_busy) begin
        ctl.stall[STG_PC] = 1'b1;
      end else begin
        pc_valid  = 1'b1;
        state_nxt = PC_IDLE;
      end
    end else if (bus.exc_req && !bus.mem_stallreq) begin
      // Exception overrides any upstream stall; MEM stall blocks it.
      accept    = 1'b1;
      ctl.flush = 5'b11110;
      if (bus.ibus_busy) begin
        ctl.stall[STG_PC] = 1'b1;
        state_nxt         = PC_WAIT;
      end else begin
        pc_valid  = 1'b1;
        pc_target = bus.exc_pc;
      end
    end else begin
      ctl = stall_level({bus.mem_stallreq, bus.ex_stallreq,
                         bus.id_stallreq, bus.if_stallreq});
    end
  end

  assign bus.stall          = ctl.stall;
  assign bus.flush          = ctl.flush;
  assign bus.flush_pc_valid = pc_valid;
  assign bus.flush_pc       = pc_target;

  // Redirect FSM state and the deferred redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PC_IDLE;
      pend_pc <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (accept && bus.ibus_busy) pend_pc <= bus.exc_pc;
    end
  end

  pipe_ctrl_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl.stall[STG_PC]),
    .clear (1'b0),
    .count (bus.stall_cnt)
  );

  pipe_ctrl_counter #(.CNT_W(CNT_W)) u_exc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .clear (1'b0),
    .count (bus.exc_cnt)
  );

endmodule
